calc_arbiter: RTL and testbench

- Sequencer and round-robin arbiter that shares one combinational 4-bit multi-function calculator between two requesters.
- Each requester issues operations (a, b, opcode) over a valid/ready handshake.
- The block drives the calculator's a/b/s inputs from registers, waits a programmable settle time, captures the 5-bit result, and returns it to the owning requester over a second valid/ready handshake.
- It sits between the calculator instance and the requester logic; only one operation is in flight at a time.

---
 rtl/calc_arbiter.sv | 130 +++++++++++++
 tb/tb_calc_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/calc_arbiter.sv
// Two-requester round-robin front end for a shared combinational 4-bit calculator.
// Only one operation is in flight at a time. The calculator inputs are held for WAIT_CYCLES cycles before its result is captured.
module calc_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic [2:0] req0_op,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic [2:0] req1_op,
    output logic       rsp0_valid,
    input  logic       rsp0_ready,
    output logic       rsp1_valid,
    input  logic       rsp1_ready,
    output logic [4:0] rsp_data,
    output logic       rsp_err,
    output logic [3:0] calc_a,
    output logic [3:0] calc_b,
    output logic [2:0] calc_s,
    input  logic [4:0] calc_y,
    output logic       busy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // Requesters may not rely on ready before asserting valid. Responses hold valid/data until taken.
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t     state, state_nxt;
    logic       last_served;
    logic       owner;
    logic [3:0] cnt;
    logic       grant_vld;
    logic       grant;
    logic       rsp_take;
    logic [3:0] sel_a;
    logic [3:0] sel_b;
    logic [2:0] sel_op;

    // Priority flips to the requester that was not served last whenever both contend.
    always_comb begin
        grant_vld = 1'b0;
        grant     = 1'b0;
        if (state == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant_vld = 1'b1;
                grant     = ~last_served;
            end else if (req0_valid) begin
                grant_vld = 1'b1;
                grant     = 1'b0;
            end else if (req1_valid) begin
                grant_vld = 1'b1;
                grant     = 1'b1;
            end
        end
    end

    assign req0_ready = grant_vld && !grant;
    assign req1_ready = grant_vld && grant;
    assign sel_a      = grant ? req1_a  : req0_a;
    assign sel_b      = grant ? req1_b  : req0_b;
    assign sel_op     = grant ? req1_op : req0_op;
    assign rsp_take   = owner ? rsp1_ready : rsp0_ready;
    assign busy       = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vld) state_nxt = EXEC;
            EXEC:    if (cnt == 4'd1) state_nxt = RESP;
            RESP:    if (rsp_take) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            calc_a      <= '0;
            calc_b      <= '0;
            calc_s      <= '0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            rsp0_valid  <= 1'b0;
            rsp1_valid  <= 1'b0;
            last_served <= 1'b1;
            owner       <= 1'b0;
            cnt         <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        calc_a  <= sel_a;
                        calc_b  <= sel_b;
                        calc_s  <= sel_op;
                        owner   <= grant;
                        rsp_err <= (sel_op > 3'd5);
                        cnt     <= WAIT_INIT;
                    end
                end
                EXEC: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        rsp_data   <= calc_y;
                        rsp0_valid <= !owner;
                        rsp1_valid <= owner;
                    end
                end
                RESP: begin
                    if (rsp_take) begin
                        rsp0_valid  <= 1'b0;
                        rsp1_valid  <= 1'b0;
                        last_served <= owner;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_arbiter.sv
// Directed bench for calc_arbiter. It uses two instances (WAIT_CYCLES=1 and 3) that share requester inputs.
// A small combinational calculator feeds each instance.
module tb_calc_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 0, req1_valid = 0;
    logic [3:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic [2:0] req0_op = 0, req1_op = 0;
    logic       rsp0_ready = 0, rsp1_ready = 0;

    logic       d1_req0_ready, d1_req1_ready, d1_rsp0_valid, d1_rsp1_valid, d1_rsp_err, d1_busy;
    logic [4:0] d1_rsp_data, d1_calc_y;
    logic [3:0] d1_calc_a, d1_calc_b;
    logic [2:0] d1_calc_s;
    logic       d3_req0_ready, d3_req1_ready, d3_rsp0_valid, d3_rsp1_valid, d3_rsp_err, d3_busy;
    logic [4:0] d3_rsp_data, d3_calc_y;
    logic [3:0] d3_calc_a, d3_calc_b;
    logic [2:0] d3_calc_s;

    int n_checks = 0;
    int n_fail   = 0;
    logic [4:0] exp_q[$];

    always #5 clk = ~clk;

    // Calculator: add, sub, and, or, compare {eq,gt,lt}, xor; opcodes 6/7 give 0.
    function automatic logic [4:0] calc_fn(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
        case (s)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {2'b00, a == b, a > b, a < b};
            3'd5:    return {1'b0, a ^ b};
            default: return 5'd0;
        endcase
    endfunction

    assign d1_calc_y = calc_fn(d1_calc_a, d1_calc_b, d1_calc_s);
    assign d3_calc_y = calc_fn(d3_calc_a, d3_calc_b, d3_calc_s);

    calc_arbiter #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(d1_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(d1_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(d1_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(d1_rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(d1_rsp_data), .rsp_err(d1_rsp_err),
        .calc_a(d1_calc_a), .calc_b(d1_calc_b), .calc_s(d1_calc_s), .calc_y(d1_calc_y), .busy(d1_busy)
    );

    calc_arbiter #(.WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(d3_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(d3_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(d3_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(d3_rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(d3_rsp_data), .rsp_err(d3_rsp_err),
        .calc_a(d3_calc_a), .calc_b(d3_calc_b), .calc_s(d3_calc_s), .calc_y(d3_calc_y), .busy(d3_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One uncontended operation on the WAIT_CYCLES=1 instance, response taken immediately.
    task automatic run_op(input bit who, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                          input logic [4:0] exp_data, input logic exp_err);
        @(negedge clk);
        req0_valid = !who; req1_valid = who;
        req0_a = a; req0_b = b; req0_op = op;
        req1_a = a; req1_b = b; req1_op = op;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        check("op_grant", {d1_req1_ready, d1_req0_ready}, who ? 2'b10 : 2'b01);
        exp_q.push_back(exp_data);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        check("op_exec_busy", d1_busy, 1);
        check("op_calc_s", d1_calc_s, op);
        @(negedge clk); #1;
        check("op_rsp_valid", {d1_rsp1_valid, d1_rsp0_valid}, who ? 2'b10 : 2'b01);
        check("op_rsp_data", d1_rsp_data, exp_q.pop_front());
        check("op_rsp_err", d1_rsp_err, exp_err);
        @(negedge clk); #1;
        check("op_idle_busy", d1_busy, 0);
        check("op_idle_valid", {d1_rsp1_valid, d1_rsp0_valid}, 0);
    endtask

    initial begin
        logic seen;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_calc", {d1_calc_a, d1_calc_b, d1_calc_s}, 0);
        check("rst_rsp", {d1_rsp_data, d1_rsp_err, d1_rsp1_valid, d1_rsp0_valid}, 0);
        check("rst_busy", {d3_busy, d1_busy}, 0);
        check("rst_ready", {d1_req1_ready, d1_req0_ready}, 0);

        // 3+5 = 8, then 2-5 = -3 -> 5'b11101
        run_op(1'b0, 4'd3, 4'd5, 3'd0, 5'd8, 1'b0);
        run_op(1'b1, 4'd2, 4'd5, 3'd1, 5'd29, 1'b0);

        // Both contend continuously: grants alternate starting with requester 0; 7 cmp 7 -> eq -> 4
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 4'd7; req0_b = 4'd7; req0_op = 3'd4;
        req1_a = 4'd7; req1_b = 4'd7; req1_op = 3'd4;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_grant", {d1_req1_ready, d1_req0_ready}, (i % 2) ? 2'b10 : 2'b01);
            @(negedge clk); #1;
            check("rr_exec_ready", {d1_req1_ready, d1_req0_ready}, 0);
            @(negedge clk); #1;
            check("rr_rsp_valid", {d1_rsp1_valid, d1_rsp0_valid}, (i % 2) ? 2'b10 : 2'b01);
            check("rr_rsp_data", d1_rsp_data, 5'd4);
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Backpressure on rsp0 while req1 waits and rsp1_ready is high; 9+9 = 18
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 4'd9; req0_b = 4'd9; req0_op = 3'd0;
        req1_valid = 1'b1; req1_a = 4'd1; req1_b = 4'd1; req1_op = 3'd0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b1;
        #1;
        check("bp_grant", {d1_req1_ready, d1_req0_ready}, 2'b01);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        check("bp_exec_req1_ready", d1_req1_ready, 0);
        @(negedge clk); #1;
        check("bp_rsp_valid", d1_rsp0_valid, 1);
        check("bp_rsp_data", d1_rsp_data, 5'd18);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check("bp_hold", {d1_busy, d1_rsp1_valid, d1_rsp0_valid, d1_req1_ready, d1_rsp_data},
                  {1'b1, 1'b0, 1'b1, 1'b0, 5'd18});
        end
        rsp0_ready = 1'b1;
        @(negedge clk); #1;
        check("bp_release", {d1_busy, d1_rsp0_valid}, 0);
        check("bp_next_grant", {d1_req1_ready, d1_req0_ready}, 2'b10);
        req1_valid = 1'b0;

        // Unsupported opcode still completes, result 0 with error flag
        run_op(1'b0, 4'd7, 4'd3, 3'd7, 5'd0, 1'b1);

        // WAIT_CYCLES=3: reset during EXEC abandons the operation
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd2; req0_op = 3'd0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        check("ab_grant", d3_req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        check("ab_exec", {d3_busy, d3_calc_a}, {1'b1, 4'd1});
        rst = 1'b1;
        @(negedge clk); #1;
        check("ab_rst_outputs", {d3_busy, d3_calc_a, d3_calc_b, d3_calc_s, d3_rsp_data, d3_rsp_err,
                                 d3_rsp1_valid, d3_rsp0_valid}, 0);
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk); #1;
            seen = seen | d3_rsp0_valid | d3_rsp1_valid;
        end
        check("ab_no_rsp", seen, 0);

        // 4+6 = 10, response three cycles after accept
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 4'd4; req0_b = 4'd6; req0_op = 3'd0;
        req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd5; req1_op = 3'd1;
        #1;
        check("w3_grant", {d3_req1_ready, d3_req0_ready}, 2'b01);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("w3_wait", {d3_rsp1_valid, d3_rsp0_valid}, 0);
            @(negedge clk);
        end
        #1;
        check("w3_wait", {d3_rsp1_valid, d3_rsp0_valid}, 0);
        @(negedge clk); #1;
        check("w3_rsp", {d3_rsp1_valid, d3_rsp0_valid, d3_rsp_data}, {2'b01, 5'd10});
        @(negedge clk); #1;
        check("w3_idle", {d3_busy, d3_rsp0_valid}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
